// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU operation decoder with multi-cycle MUL/DIV busy sequencing
module alu_op_sequencer #(
    parameter int OP_WIDTH    = 5,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          ALU_Op_i,
    input  logic [2:0]          funct3_i,
    output logic [OP_WIDTH-1:0] ALU_Operation_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                illegal_o
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_LUI  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_DIV  = 5'd17;
    localparam logic [4:0] OP_REM  = 5'd18;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  illegal_q;

    logic [4:0]            code_d;
    logic                  illegal_d;

    // Base integer ops shared by R-type and I-type, indexed by funct3.
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

    // Undecodable requests fall through with code ADD and the illegal flag set.
    always_comb begin
        code_d    = OP_ADD;
        illegal_d = 1'b0;
        case (ALU_Op_i)
            3'b000: begin
                case (funct7_i)
                    F7_BASE: code_d = base_op(funct3_i);
                    F7_ALT: begin
                        case (funct3_i)
                            3'b000:  code_d    = OP_SUB;
                            3'b101:  code_d    = OP_SRA;
                            default: illegal_d = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        case (funct3_i)
                            3'b000:  code_d    = OP_MUL;
                            3'b100:  code_d    = OP_DIV;
                            3'b110:  code_d    = OP_REM;
                            default: illegal_d = 1'b1;
                        endcase
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            3'b001: begin
                case (funct3_i)
                    3'b001: begin
                        if (funct7_i == F7_BASE) code_d = OP_SLL;
                        else                     illegal_d = 1'b1;
                    end
                    3'b101: begin
                        if (funct7_i == F7_BASE)     code_d = OP_SRL;
                        else if (funct7_i == F7_ALT) code_d = OP_SRA;
                        else                         illegal_d = 1'b1;
                    end
                    default: code_d = base_op(funct3_i);
                endcase
            end
            3'b010:  code_d    = OP_ADD;
            3'b011:  code_d    = OP_SUB;
            3'b111:  code_d    = OP_LUI;
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (valid_i) begin
                        op_q      <= OP_WIDTH'(code_d);
                        illegal_q <= illegal_d;
                        if (code_d == OP_MUL) begin
                            state_q <= S_BUSY;
                            cnt_q   <= MUL_LOAD;
                        end else if ((code_d == OP_DIV) || (code_d == OP_REM)) begin
                            state_q <= S_BUSY;
                            cnt_q   <= DIV_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    // Requests arriving while busy are dropped, not queued.
                    if (cnt_q == '0) state_q <= S_DONE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ALU_Operation_o = op_q;
    assign illegal_o       = illegal_q;
    assign busy_o          = (state_q == S_BUSY);
    assign done_o          = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int OPW     = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    localparam int BASE_CODE [8] = '{0, 4, 8, 9, 7, 5, 3, 6};

    logic           clk = 1'b0;
    logic           reset;
    logic           valid_i;
    logic [6:0]     funct7_i;
    logic [2:0]     ALU_Op_i;
    logic [2:0]     funct3_i;
    logic [OPW-1:0] ALU_Operation_o;
    logic           busy_o;
    logic           done_o;
    logic           illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    int m_code;
    bit m_ill;
    int m_rem;
    bit m_done;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .OP_WIDTH   (OPW),
        .MUL_LATENCY(MUL_LAT),
        .DIV_LATENCY(DIV_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .funct7_i       (funct7_i),
        .ALU_Op_i       (ALU_Op_i),
        .funct3_i       (funct3_i),
        .ALU_Operation_o(ALU_Operation_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .illegal_o      (illegal_o)
    );

    task automatic ref_decode(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              output int code, output bit ill);
        code = 0;
        ill  = 0;
        if (op == 3'd0) begin
            if (f7 == 7'h00) code = BASE_CODE[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) code = 10;
            else if (f7 == 7'h01 && f3 == 3'd0) code = 16;
            else if (f7 == 7'h01 && f3 == 3'd4) code = 17;
            else if (f7 == 7'h01 && f3 == 3'd6) code = 18;
            else ill = 1;
        end else if (op == 3'd1) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) code = 4; else ill = 1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) code = 5;
                else if (f7 == 7'h20) code = 10;
                else ill = 1;
            end else code = BASE_CODE[f3];
        end else if (op == 3'd2) code = 0;
        else if (op == 3'd3) code = 1;
        else if (op == 3'd7) code = 2;
        else ill = 1;
    endtask

    task automatic model_reset();
        m_code = 0;
        m_ill  = 0;
        m_rem  = 0;
        m_done = 0;
    endtask

    // Model: m_rem counts busy cycles still owed; a request is taken only when none remain.
    task automatic model_edge();
        int c;
        bit il;
        if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
        end else begin
            m_done = 0;
            if (valid_i) begin
                ref_decode(ALU_Op_i, funct7_i, funct3_i, c, il);
                m_code = c;
                m_ill  = il;
                if (c == 16) m_rem = MUL_LAT;
                else if (c == 17 || c == 18) m_rem = DIV_LAT;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3);
        valid_i  = v;
        ALU_Op_i = op;
        funct7_i = f7;
        funct3_i = f3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 3'd0, 7'd0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ALU_Operation_o !== 5'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", ALU_Operation_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
        n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_o); end
        reset = 1'b0;
    endtask

    task automatic test_decode_directed();
        drive(1, 3'd0, 7'h20, 3'd0);
        tick();
        n_checks++; if (ALU_Operation_o !== 5'd1 || illegal_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL r_sub got code=%0d ill=%b busy=%b want 1/0/0", ALU_Operation_o, illegal_o, busy_o); end
        drive(1, 3'd1, 7'h20, 3'd5);
        tick();
        n_checks++; if (ALU_Operation_o !== 5'd10 || illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL i_sra got code=%0d ill=%b want 10/0", ALU_Operation_o, illegal_o); end
        drive(1, 3'd1, 7'h01, 3'd5);
        tick();
        n_checks++; if (ALU_Operation_o !== 5'd0 || illegal_o !== 1'b1) begin
            n_fail++; $display("FAIL i_shift_bad got code=%0d ill=%b want 0/1", ALU_Operation_o, illegal_o); end
        drive(0, 3'd0, 7'd0, 3'd0);
        tick();
    endtask

    task automatic test_mul();
        drive(1, 3'd0, 7'h01, 3'd0);
        tick();
        n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || ALU_Operation_o !== 5'd16) begin
            n_fail++; $display("FAIL mul_busy1 got busy=%b done=%b code=%0d want 1/0/16", busy_o, done_o, ALU_Operation_o); end
        drive(1, 3'd0, 7'h20, 3'd0);
        tick();
        n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || ALU_Operation_o !== 5'd16) begin
            n_fail++; $display("FAIL mul_busy2 got busy=%b done=%b code=%0d want 1/0/16", busy_o, done_o, ALU_Operation_o); end
        tick();
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b1 || ALU_Operation_o !== 5'd16) begin
            n_fail++; $display("FAIL mul_done got busy=%b done=%b code=%0d want 0/1/16", busy_o, done_o, ALU_Operation_o); end
        drive(0, 3'd0, 7'd0, 3'd0);
        tick();
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || ALU_Operation_o !== 5'd16) begin
            n_fail++; $display("FAIL mul_idle got busy=%b done=%b code=%0d want 0/0/16", busy_o, done_o, ALU_Operation_o); end
    endtask

    task automatic test_back_to_back();
        drive(1, 3'd0, 7'h01, 3'd4);
        tick();
        for (int i = 0; i < DIV_LAT; i++) begin
            n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || ALU_Operation_o !== 5'd17) begin
                n_fail++; $display("FAIL div_busy[%0d] got busy=%b done=%b code=%0d want 1/0/17", i, busy_o, done_o, ALU_Operation_o); end
            tick();
        end
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL div_done got busy=%b done=%b want 0/1", busy_o, done_o); end
        tick();
        n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || ALU_Operation_o !== 5'd17) begin
            n_fail++; $display("FAIL div_rearm got busy=%b done=%b code=%0d want 1/0/17", busy_o, done_o, ALU_Operation_o); end
        drive(0, 3'd0, 7'd0, 3'd0);
        repeat (DIV_LAT + 1) tick();
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL div_drain got busy=%b done=%b want 0/0", busy_o, done_o); end
    endtask

    task automatic test_reset_mid_busy();
        drive(1, 3'd0, 7'h01, 3'd4);
        tick();
        drive(0, 3'd0, 7'd0, 3'd0);
        repeat (4) tick();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre got busy=%b want 1", busy_o); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ALU_Operation_o !== 5'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || illegal_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_async got code=%0d busy=%b done=%b ill=%b want all 0", ALU_Operation_o, busy_o, done_o, illegal_o); end
        #1 reset = 1'b0;
        model_reset();
        drive(1, 3'd0, 7'h00, 3'd0);
        tick();
        n_checks++; if (ALU_Operation_o !== 5'd0 || illegal_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_add got code=%0d ill=%b busy=%b done=%b want 0/0/0/0", ALU_Operation_o, illegal_o, busy_o, done_o); end
        drive(1, 3'd0, 7'h00, 3'd3);
        tick();
        n_checks++; if (ALU_Operation_o !== 5'd9) begin n_fail++; $display("FAIL abort_sltu got %0d want 9", ALU_Operation_o); end
        drive(0, 3'd0, 7'd0, 3'd0);
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            tick();
            n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_nodone[%0d] got %b want 0", i, done_o); end
        end
    endtask

    task automatic test_lui_illegal();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'd7, 7'($urandom), 3'($urandom));
            tick();
            n_checks++; if (ALU_Operation_o !== 5'd2 || illegal_o !== 1'b0) begin
                n_fail++; $display("FAIL lui[%0d] got code=%0d ill=%b want 2/0", i, ALU_Operation_o, illegal_o); end
            drive(1, 3'($urandom_range(4, 6)), 7'($urandom), 3'($urandom));
            tick();
            n_checks++; if (ALU_Operation_o !== 5'd0 || illegal_o !== 1'b1) begin
                n_fail++; $display("FAIL bad_class[%0d] got code=%0d ill=%b want 0/1", i, ALU_Operation_o, illegal_o); end
        end
        drive(0, 3'd0, 7'd0, 3'd0);
        tick();
    endtask

    task automatic test_random();
        logic [6:0] f7;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1)) : 3'($urandom), f7, 3'($urandom));
            tick();
            n_checks++; if (ALU_Operation_o !== 5'(m_code) || illegal_o !== m_ill) begin
                n_fail++; $display("FAIL rnd_code[%0d] got code=%0d ill=%b want %0d/%b", i, ALU_Operation_o, illegal_o, m_code, m_ill); end
            n_checks++; if (busy_o !== (m_rem > 0) || done_o !== m_done) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d] got busy=%b done=%b want %b/%b", i, busy_o, done_o, m_rem > 0, m_done); end
            n_checks++; if (busy_o && done_o) begin
                n_fail++; $display("FAIL rnd_excl[%0d] got busy=1 done=1 want not both", i); end
        end
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_mul();
        test_back_to_back();
        test_reset_mid_busy();
        test_lui_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter OP_WIDTH, default 5, width of ALU operation code; SHALL be >= 5.
REQ-002 Parameter MUL_LATENCY, default 2, busy cycles for MUL; SHALL be >= 1.
REQ-003 Parameter DIV_LATENCY, default 32, busy cycles for DIV/REM; SHALL be >= 1.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  decode request; fields sampled on a clk edge when high and block accepting.
REQ-007 funct7_i  input  7  full funct7 field of instruction.
REQ-008 ALU_Op_i  input  3  operation class from main control.
REQ-009 funct3_i  input  3  funct3 field of instruction.
REQ-010 ALU_Operation_o  output  OP_WIDTH  registered ALU operation code, zero-extended.
REQ-011 busy_o  output  1  multi-cycle operation in progress; core stalls.
REQ-012 done_o  output  1  one-cycle pulse, multi-cycle operation finished.
REQ-013 illegal_o  output  1  registered flag, last accepted request undecodable.

Function
REQ-014 Codes SHALL be: ADD 0, SUB 1, LUI 2, OR 3, SLL 4, SRL 5, AND 6, XOR 7, SLT 8, SLTU 9, SRA 10, MUL 16, DIV 17, REM 18.
REQ-015 ALU_Op 000 (R-type), funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-016 ALU_Op 000, funct7 0100000: funct3 000 SUB, 101 SRA; other funct3 illegal.
REQ-017 ALU_Op 000, funct7 0000001: funct3 000 MUL, 100 DIV, 110 REM; other funct3 illegal; any other funct7 illegal.
REQ-018 ALU_Op 001 (I-type): funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, funct7 ignored for these.
REQ-019 ALU_Op 001, funct3 001: SLL only when funct7 = 0000000, else illegal; funct3 101: SRL for funct7 0000000, SRA for 0100000, else illegal.
REQ-020 ALU_Op 010 (load/store address) SHALL decode ADD; ALU_Op 011 (branch compare) SUB; ALU_Op 111 (LUI) LUI; all regardless of funct fields.
REQ-021 ALU_Op 100, 101, 110 SHALL be illegal.
REQ-022 Illegal request SHALL register code ADD (0) and illegal_o = 1; legal request registers illegal_o = 0.
REQ-023 FSM states IDLE, BUSY, DONE; block accepts valid_i in IDLE and DONE only; valid_i in BUSY ignored, no state change.
REQ-024 Accepted request: ALU_Operation_o and illegal_o update on the accepting edge (latency 1 cycle) and hold until next accepted request.
REQ-025 Accepted single-cycle code (anything but MUL/DIV/REM, including illegal): next state IDLE, busy_o stays 0, no done_o.
REQ-026 Accepted MUL: next state BUSY, busy_o = 1 for exactly MUL_LATENCY cycles after accepting edge; DIV/REM likewise for DIV_LATENCY cycles.
REQ-027 Down-counter width clog2(max(MUL_LATENCY,DIV_LATENCY)+1) SHALL load LATENCY-1 on acceptance, decrement each BUSY cycle; BUSY -> DONE on edge where counter is 0.
REQ-028 DONE: busy_o = 0, done_o = 1 for exactly one cycle; DONE -> IDLE unless valid_i accepted, which follows REQ-025/026 (back-to-back MUL gives done_o pulse coinciding with new acceptance).
REQ-029 busy_o and done_o SHALL be direct state decodes, never both 1.
REQ-030 Latency 1: BUSY holds one cycle, then DONE.

Reset
REQ-031 reset high SHALL immediately, independent of clk, force state IDLE, counter 0, ALU_Operation_o 0, busy_o 0, done_o 0, illegal_o 0.
REQ-032 reset asserted during BUSY SHALL abort the operation with no done_o pulse; first edge after release accepts valid_i.

Verification
REQ-033 valid_i=1, ALU_Op 000, funct7 0100000, funct3 000 -> next cycle ALU_Operation_o = 1, illegal_o 0, busy_o 0.
REQ-034 ALU_Op 001, funct3 101, funct7 0100000 -> code 10; same with funct7 0000001 -> code 0, illegal_o 1.
REQ-035 MUL accepted, MUL_LATENCY 2 -> busy_o high 2 cycles, then done_o high 1 cycle, ALU_Operation_o = 16 throughout; SUB presented while busy ignored.
REQ-036 DIV accepted, DIV_LATENCY 32, then DIV presented continuously -> busy_o 32 cycles, done_o pulse, busy_o reasserts next cycle, ALU_Operation_o = 17.
REQ-037 reset pulsed mid-clock at BUSY cycle 5 of DIV -> all outputs 0 immediately, no done_o, subsequent ADD accepted normally.
REQ-038 ALU_Op 111, random funct7/funct3 -> code 2; ALU_Op 110 -> code 0, illegal_o 1.
